// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the N-channel memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int RD_OP_W     = 3;
    localparam int WR_OP_W     = 2;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Width of a channel index; a single channel still needs a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches the request
//                vector upward from ptr_i (wrapping) and returns the first
//                requester as one-hot grant and as an index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [N-1:0] w_upper;
    logic [N-1:0] w_pool;

    // Prefer requesters at or above the pointer; wrap to the full set otherwise.
    always_comb begin
        w_upper = '0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(ptr_i)) begin
                w_upper[i] = req_i[i];
            end
        end
        w_pool  = (|w_upper) ? w_upper : req_i;
        gnt_o   = '0;
        idx_o   = '0;
        // Walk downward so the lowest set bit of the pool is the one that sticks.
        for (int i = N - 1; i >= 0; i--) begin
            if (w_pool[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
        valid_o = |req_i;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : N-channel arbiter sharing one strobe/ready memory port.
//                One buffered request per channel, round-robin grant, one
//                outstanding downstream transaction.
//                Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a
//                transaction after TIMEOUT cycles without mem_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              ch_init,
    input  logic [NUM_CH*RD_OP_W-1:0]      ch_read_op,
    input  logic [NUM_CH*WR_OP_W-1:0]      ch_write_op,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]              ch_ready,
    output logic [NUM_CH-1:0]              ch_err,
    output logic [DATA_WIDTH-1:0]          ch_rdata,
    output logic                           mem_init,
    output logic [RD_OP_W-1:0]             mem_read_op,
    output logic [WR_OP_W-1:0]             mem_write_op,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic                           mem_ready,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int IW = ptr_width(NUM_CH);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           ptr_q;
    logic [NUM_CH-1:0]       gnt_q;
    logic [NUM_CH-1:0]       busy_q, busy_d;
    logic [NUM_CH-1:0]       pend_q, pend_d;
    logic [RD_OP_W-1:0]      slot_rop_q  [NUM_CH];
    logic [WR_OP_W-1:0]      slot_wop_q  [NUM_CH];
    logic [ADDR_WIDTH-1:0]   slot_addr_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   slot_wd_q   [NUM_CH];
    logic [RD_OP_W-1:0]      mem_rop_q;
    logic [WR_OP_W-1:0]      mem_wop_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wd_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [NUM_CH-1:0]       w_accept;
    logic [NUM_CH-1:0]       w_release;
    logic [NUM_CH-1:0]       w_grant;
    logic [NUM_CH-1:0]       w_pick_gnt;
    logic [IW-1:0]           w_pick_idx;
    logic                    w_any;
    logic                    w_do_grant;
    logic                    w_timeout;

    rr_pick #(
        .N  (NUM_CH),
        .IW (IW)
    ) u_pick (
        .req_i   (pend_q),
        .ptr_i   (ptr_q),
        .gnt_o   (w_pick_gnt),
        .idx_o   (w_pick_idx),
        .valid_o (w_any)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] w_absent;
    logic          err_q, err_d;

    // Cycles without mem_ready so far, counting the ISSUE cycle as the first.
    assign w_absent  = (state_q == ST_ISSUE) ? CW'(1) : cnt_q + CW'(1);
    assign w_timeout = ~mem_ready & (w_absent == CW'(TIMEOUT));

    // Watchdog counter and error flag of the outstanding transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign ch_err = (state_q == ST_RESP && err_q) ? gnt_q : '0;
`else
    assign w_timeout = 1'b0;
    assign ch_err    = '0;
`endif

    // Slot bookkeeping: a slot frees in RESP, so the granted channel may
    // re-request in that very cycle.
    always_comb begin
        w_release = (state_q == ST_RESP) ? gnt_q : '0;
        w_accept  = ch_init & (~busy_q | w_release);
        w_grant   = w_do_grant ? w_pick_gnt : '0;
        busy_d    = (busy_q & ~w_release) | w_accept;
        pend_d    = (pend_q & ~w_grant) | w_accept;
    end

    // Capture request fields and slot flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            pend_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_rop_q[i]  <= '0;
                slot_wop_q[i]  <= '0;
                slot_addr_q[i] <= '0;
                slot_wd_q[i]   <= '0;
            end
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_accept[i]) begin
                    slot_rop_q[i]  <= ch_read_op[RD_OP_W*i +: RD_OP_W];
                    slot_wop_q[i]  <= ch_write_op[WR_OP_W*i +: WR_OP_W];
                    slot_addr_q[i] <= ch_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                    slot_wd_q[i]   <= ch_wdata[DATA_WIDTH*i +: DATA_WIDTH];
                end
            end
        end
    end

    // Next-state logic; mem_ready is only meaningful in ISSUE and WAIT.
    always_comb begin
        state_d    = state_q;
        w_do_grant = 1'b0;
        rdata_d    = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        err_d      = err_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    w_do_grant = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d = w_absent;
`endif
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end else if (w_timeout) begin
                    rdata_d = '0;
                    state_d = ST_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (w_any) begin
                    w_do_grant = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // On grant: load the downstream port, remember the winner, advance ptr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            mem_rop_q  <= '0;
            mem_wop_q  <= '0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else if (w_do_grant) begin
            ptr_q      <= (w_pick_idx == IW'(NUM_CH - 1)) ? '0 : w_pick_idx + IW'(1);
            gnt_q      <= w_pick_gnt;
            mem_rop_q  <= slot_rop_q[w_pick_idx];
            mem_wop_q  <= slot_wop_q[w_pick_idx];
            mem_addr_q <= slot_addr_q[w_pick_idx];
            mem_wd_q   <= slot_wd_q[w_pick_idx];
        end
    end

    assign mem_init     = (state_q == ST_ISSUE);
    assign mem_read_op  = mem_rop_q;
    assign mem_write_op = mem_wop_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wd_q;
    assign ch_ready     = (state_q == ST_RESP) ? gnt_q : '0;
    assign ch_rdata     = (state_q == ST_RESP) ? rdata_q : '0;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a transaction-level
//                reference model, directed scenarios and random traffic.
//                Define MEM_ARB_TIMEOUT_EN to exercise the watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int MAXLAT = 12;
`else
    localparam int MAXLAT = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_init;
    logic [NCH*3-1:0]  ch_read_op;
    logic [NCH*2-1:0]  ch_write_op;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_ready;
    logic [NCH-1:0]    ch_err;
    logic [DW-1:0]     ch_rdata;
    logic              mem_init;
    logic [2:0]        mem_read_op;
    logic [1:0]        mem_write_op;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata;

    mem_arbiter #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_init(ch_init), .ch_read_op(ch_read_op), .ch_write_op(ch_write_op),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ready(ch_ready), .ch_err(ch_err), .ch_rdata(ch_rdata),
        .mem_init(mem_init), .mem_read_op(mem_read_op), .mem_write_op(mem_write_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: slots, round-robin pointer, and the one outstanding txn.
    bit          m_busy [NCH];
    bit          m_pend [NCH];
    logic [2:0]  m_rop  [NCH];
    logic [1:0]  m_wop  [NCH];
    logic [31:0] m_addr [NCH];
    logic [31:0] m_wd   [NCH];
    int          m_ptr;
    bit          m_txn;      // a transaction owns the downstream port
    int          m_ch;
    bit          m_issued;   // its mem_init has already been shown
    int          m_age;
    bit          m_resp;     // a response is due this cycle
    int          m_rch;
    logic [31:0] m_rdata;
    bit          m_err;
    bit          m_fresh;    // nothing granted since reset
    logic [2:0]  e_rop;
    logic [1:0]  e_wop;
    logic [31:0] e_addr;
    logic [31:0] e_wd;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_busy[i] = 0; m_pend[i] = 0;
        end
        m_ptr = 0; m_txn = 0; m_issued = 0; m_age = 0; m_ch = 0;
        m_resp = 0; m_rch = 0; m_rdata = '0; m_err = 0; m_fresh = 1;
        e_rop = '0; e_wop = '0; e_addr = '0; e_wd = '0;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_update();
        bit          was_free;
        bit          acc [NCH];
        bit          nr;
        int          nch;
        logic [31:0] nd;
        bit          ne;
        was_free = !m_txn;
        nr = 0; nch = 0; nd = '0; ne = 0;
        if (m_txn) begin
            m_age++;
            if (mem_ready) begin
                nr = 1; nch = m_ch; nd = mem_rdata; ne = 0; m_txn = 0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (m_age == TMO) begin
                nr = 1; nch = m_ch; nd = '0; ne = 1; m_txn = 0;
            end
`endif
            else begin
                m_issued = 1;
            end
        end
        for (int i = 0; i < NCH; i++)
            acc[i] = ch_init[i] && (!m_busy[i] || (m_resp && m_rch == i));
        if (m_resp) m_busy[m_rch] = 0;
        if (was_free) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (m_pend[c]) begin
                    m_txn = 1; m_ch = c; m_issued = 0; m_age = 0; m_fresh = 0;
                    e_rop = m_rop[c]; e_wop = m_wop[c]; e_addr = m_addr[c]; e_wd = m_wd[c];
                    m_pend[c] = 0;
                    m_ptr = (c + 1) % NCH;
                    break;
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (acc[i]) begin
                m_busy[i] = 1; m_pend[i] = 1;
                m_rop[i]  = ch_read_op[3*i +: 3];
                m_wop[i]  = ch_write_op[2*i +: 2];
                m_addr[i] = ch_addr[AW*i +: AW];
                m_wd[i]   = ch_wdata[DW*i +: DW];
            end
        end
        m_resp = nr; m_rch = nch; m_rdata = nd; m_err = ne;
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic check_outputs();
        logic [NCH-1:0] er;
        logic [NCH-1:0] ee;
        er = m_resp ? (NCH'(1) << m_rch) : '0;
        ee = (m_resp && m_err) ? (NCH'(1) << m_rch) : '0;
        cmp("mem_init", 64'(mem_init), 64'(m_txn && !m_issued));
        cmp("ch_ready", 64'(ch_ready), 64'(er));
        cmp("ch_err", 64'(ch_err), 64'(ee));
        if (m_resp) cmp("ch_rdata", 64'(ch_rdata), 64'(m_rdata));
        if (m_txn || m_fresh) begin
            cmp("mem_addr", 64'(mem_addr), 64'(e_addr));
            cmp("mem_wdata", 64'(mem_wdata), 64'(e_wd));
            cmp("mem_read_op", 64'(mem_read_op), 64'(e_rop));
            cmp("mem_write_op", 64'(mem_write_op), 64'(e_wop));
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        ch_init   = '0;
        mem_ready = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [2:0] r, input logic [1:0] w,
                           input logic [31:0] a, input logic [31:0] d);
        ch_init[i]              = 1'b1;
        ch_read_op[3*i +: 3]    = r;
        ch_write_op[2*i +: 2]   = w;
        ch_addr[AW*i +: AW]     = a;
        ch_wdata[DW*i +: DW]    = d;
    endtask

    // Assert reset dly after the current negedge and check outputs clear at once.
    task automatic do_reset(input int dly);
        #(dly);
        reset = 1'b0;
        #1;
        cmp("rst_mem_init", 64'(mem_init), 64'd0);
        cmp("rst_ch_ready", 64'(ch_ready), 64'd0);
        cmp("rst_ch_err", 64'(ch_err), 64'd0);
        cmp("rst_ch_rdata", 64'(ch_rdata), 64'd0);
        cmp("rst_mem_addr", 64'(mem_addr), 64'd0);
        cmp("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        cmp("rst_mem_ops", 64'({mem_read_op, mem_write_op}), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        ch_init   = '0;
        mem_ready = 1'b0;
    endtask

    initial begin
        int q[$];
        int inits;
        int rw;
        reset = 1'b0; ch_init = '0; ch_read_op = '0; ch_write_op = '0;
        ch_addr = '0; ch_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        model_reset();
        @(negedge clk);
        do_reset(0);

        // Single read on ch0.
        for (int c = 0; c < 8; c++) begin
            check_outputs();
            case (c)
                0: set_req(0, 3'b001, 2'b00, 32'h100, 32'h0);
                2: begin
                    cmp("t1_init_c2", 64'(mem_init), 64'd1);
                    cmp("t1_addr_c2", 64'(mem_addr), 64'h100);
                end
                3: cmp("t1_noinit_c3", 64'(mem_init), 64'd0);
                4: begin mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; end
                5: begin
                    cmp("t1_ready_c5", 64'(ch_ready), 64'b01);
                    cmp("t1_rdata_c5", 64'(ch_rdata), 64'hDEADBEEF);
                end
                default: ;
            endcase
            tick();
        end

        // Simultaneous requests, one-cycle memory.
        do_reset(0);
        for (int c = 0; c < 10; c++) begin
            check_outputs();
            case (c)
                0: begin
                    set_req(0, 3'b010, 2'b00, 32'h200, 32'h0);
                    set_req(1, 3'b011, 2'b00, 32'h300, 32'h0);
                end
                2: begin
                    cmp("t2_init0_c2", 64'(mem_init), 64'd1);
                    cmp("t2_addr0_c2", 64'(mem_addr), 64'h200);
                end
                3: begin mem_ready = 1'b1; mem_rdata = 32'hAAAA0001; end
                4: cmp("t2_ready0_c4", 64'(ch_ready), 64'b01);
                5: begin
                    cmp("t2_init1_c5", 64'(mem_init), 64'd1);
                    cmp("t2_addr1_c5", 64'(mem_addr), 64'h300);
                end
                6: begin mem_ready = 1'b1; mem_rdata = 32'hBBBB0002; end
                7: begin
                    cmp("t2_ready1_c7", 64'(ch_ready), 64'b10);
                    cmp("t2_rdata1_c7", 64'(ch_rdata), 64'hBBBB0002);
                end
                default: ;
            endcase
            tick();
        end

        // Both channels re-request on every completion: strict alternation.
        do_reset(0);
        for (int c = 0; c < 80 && q.size() < 8; c++) begin
            check_outputs();
            if (c == 0) begin
                set_req(0, 3'($urandom), 2'($urandom), $urandom, $urandom);
                set_req(1, 3'($urandom), 2'($urandom), $urandom, $urandom);
            end
            for (int i = 0; i < NCH; i++) begin
                if (ch_ready[i]) begin
                    q.push_back(i);
                    set_req(i, 3'($urandom), 2'($urandom), $urandom, $urandom);
                end
            end
            if (m_txn && m_issued) begin
                mem_ready = 1'b1; mem_rdata = $urandom;
            end
            tick();
        end
        cmp("t3_count", 64'(q.size()), 64'd8);
        for (int k = 0; k < 8 && k < q.size(); k++)
            cmp($sformatf("t3_grant%0d", k), 64'(q[k]), 64'(k % 2));

        // ch1 write; a second init while busy is dropped.
        do_reset(0);
        inits = 0;
        for (int c = 0; c < 10; c++) begin
            check_outputs();
            inits += int'(mem_init);
            case (c)
                0: set_req(1, 3'b000, 2'b11, 32'h2004, 32'h12345678);
                1: set_req(1, 3'b101, 2'b01, 32'h9999, 32'hFFFF0000);
                2: begin
                    cmp("t4_init_c2", 64'(mem_init), 64'd1);
                    cmp("t4_addr", 64'(mem_addr), 64'h2004);
                    cmp("t4_wop", 64'(mem_write_op), 64'b11);
                    cmp("t4_wdata", 64'(mem_wdata), 64'h12345678);
                    cmp("t4_rop", 64'(mem_read_op), 64'd0);
                end
                3: begin mem_ready = 1'b1; mem_rdata = 32'h0; end
                4: cmp("t4_ready_c4", 64'(ch_ready), 64'b10);
                default: ;
            endcase
            tick();
        end
        cmp("t4_one_init", 64'(inits), 64'd1);

        // Reset during WAIT abandons the transaction.
        do_reset(0);
        for (int c = 0; c < 3; c++) begin
            check_outputs();
            if (c == 0) set_req(0, 3'b010, 2'b00, 32'hABC0, 32'h0);
            if (c == 2) cmp("t5_init_c2", 64'(mem_init), 64'd1);
            tick();
        end
        check_outputs();
        cmp("t5_addr_wait", 64'(mem_addr), 64'hABC0);
        do_reset(2);
        for (int c = 0; c < 8; c++) begin
            check_outputs();
            case (c)
                1: begin mem_ready = 1'b1; mem_rdata = 32'h55; end
                2: cmp("t5_no_ready", 64'(ch_ready), 64'd0);
                3: set_req(0, 3'b001, 2'b00, 32'h4440, 32'h0);
                5: begin
                    cmp("t5_init_new", 64'(mem_init), 64'd1);
                    cmp("t5_addr_new", 64'(mem_addr), 64'h4440);
                end
                6: begin mem_ready = 1'b1; mem_rdata = 32'h77; end
                7: begin
                    cmp("t5_ready_new", 64'(ch_ready), 64'b01);
                    cmp("t5_rdata_new", 64'(ch_rdata), 64'h77);
                end
                default: ;
            endcase
            tick();
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: memory never answers.
        do_reset(0);
        for (int c = 0; c < 15; c++) begin
            check_outputs();
            case (c)
                0: set_req(0, 3'b001, 2'b00, 32'h500, 32'h0);
                2: cmp("t6_init_c2", 64'(mem_init), 64'd1);
                9: cmp("t6_noready_c9", 64'(ch_ready), 64'd0);
                10: begin
                    cmp("t6_ready_c10", 64'(ch_ready), 64'b01);
                    cmp("t6_err_c10", 64'(ch_err), 64'b01);
                    cmp("t6_rdata_c10", 64'(ch_rdata), 64'd0);
                end
                12: begin mem_ready = 1'b1; mem_rdata = 32'hCAFE; end
                13: cmp("t6_late_ignored", 64'(ch_ready), 64'd0);
                default: ;
            endcase
            tick();
        end
`endif

        // Random traffic with random memory latency and stray mem_ready.
        do_reset(0);
        rw = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset(3);
            check_outputs();
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 2) == 0)
                    set_req(i, 3'($urandom), 2'($urandom), $urandom, $urandom);
            if (m_txn) begin
                if (!m_issued) rw = $urandom_range(0, MAXLAT);
                if (rw == 0) begin
                    mem_ready = 1'b1; mem_rdata = $urandom;
                end else begin
                    rw--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ready = 1'b1; mem_rdata = $urandom;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel arbiter sharing one memory port between several requesters, e.g. CPU instruction/data paths and a DMA. Every channel uses the same strobe/ready protocol as the core memory port: a one-cycle init strobe with read/write ops, address and write data, answered later by a one-cycle ready with read data. The arbiter buffers one request per channel, grants round-robin, and keeps one transaction outstanding on the downstream port. It sits between the cpu and the memory/bus controller.

## Interface
Parameters:
- NUM_CH, 2: number of requesting channels (≥1)
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width
- TIMEOUT, 255: watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ch_init  in  NUM_CH  per-channel request strobe
- ch_read_op  in  NUM_CH*3  per-channel read op, flattened, channel i at [3i+2:3i]
- ch_write_op  in  NUM_CH*2  per-channel write op, flattened
- ch_addr  in  NUM_CH*ADDR_WIDTH  per-channel address, flattened
- ch_wdata  in  NUM_CH*DATA_WIDTH  per-channel write data, flattened
- ch_ready  out  NUM_CH  one-cycle completion pulse per channel
- ch_err  out  NUM_CH  one-cycle timeout flag, coincident with ch_ready
- ch_rdata  out  DATA_WIDTH  read data, shared, valid while any ch_ready bit is high
- mem_init  out  1  downstream request strobe
- mem_read_op  out  3  downstream read op
- mem_write_op  out  2  downstream write op
- mem_addr  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_ready  in  1  downstream completion
- mem_rdata  in  DATA_WIDTH  downstream read data

## Operation
- Per-channel slot: busy flag plus captured read_op, write_op, addr and wdata.
- ch_init[i] with slot i not busy: at that edge, capture fields and set busy and pending.
- ch_init[i] with slot i busy: ignored, no state change.
- Ops are opaque. They are forwarded unchanged and never decoded.
- States:
  - IDLE: if any pending, pick a channel, load downstream registers, clear its pending, go to ISSUE.
  - ISSUE: mem_init=1 for this one cycle only; then WAIT.
  - WAIT: hold fields stable; on mem_ready capture mem_rdata, go to RESP.
  - RESP: ch_ready[g]=1, clear busy[g]; if pending, arbitrate as in IDLE and go to ISSUE, else go to IDLE.
- mem_ready sampled in ISSUE is treated as in WAIT (zero-wait memory). mem_ready in IDLE or RESP is ignored.
- Round-robin: search from pointer ptr upward, modulo NUM_CH. After granting g, ptr = (g+1) mod NUM_CH. NUM_CH=1 is legal and degenerates to pass-through with buffering.
- ch_init[g] during RESP for the granted channel is accepted, because the slot frees at that edge.

## Timing
- Reset values: all outputs 0; state IDLE; ptr 0; all busy/pending cleared. Reset is immediate, including mid-transaction. An in-flight downstream transaction is abandoned and no ch_ready follows.
- Latency with ch_init in cycle 0 and an idle arbiter: grant at end of cycle 1; mem_init in cycle 2; mem_ready no earlier than cycle 2; ch_ready one cycle after mem_ready.
- Back-to-back: the next mem_init comes the cycle after RESP, so the downstream port has at most one idle cycle between transactions.
- mem_addr, mem_*_op and mem_wdata are registered and stable from ISSUE through the cycle mem_ready is seen.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter starts at the ISSUE cycle.
  - If mem_ready is absent for TIMEOUT consecutive cycles, go to RESP with ch_ready[g]=1, ch_err[g]=1 and ch_rdata=0.
  - A late mem_ready is then ignored.
- MEM_ARB_TIMEOUT_EN undefined: WAIT lasts indefinitely, ch_err is tied 0, and no counter is built.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - op width constants (read op 3, write op 2)
  - default TIMEOUT
- Sub-module rr_pick: combinational round-robin picker. Inputs: request vector and ptr. Outputs: one-hot grant, grant index, any-valid.

## Test plan
- Single read, ch0: ch_init cycle 0, addr 0x100; mem_ready cycle 4, rdata 0xDEADBEEF -> mem_init only in cycle 2 with addr 0x100; ch_ready[0] and ch_rdata 0xDEADBEEF in cycle 5.
- Simultaneous ch0/ch1 init in cycle 0, memory ready 1 cycle after each mem_init -> ch0 mem_init cycle 2, ch0 ready cycle 4, ch1 mem_init cycle 5, ch1 ready cycle 7.
- Both channels re-request on every ch_ready for 8 transactions -> grant order 0,1,0,1,0,1,0,1, with no starvation.
- ch1 write: write_op 2'b11, wdata 0x12345678, addr 0x2004 -> same values on mem_* during mem_init; second ch_init[1] before completion is ignored (exactly one mem_init).
- reset low during WAIT -> all outputs 0 immediately; after release, no ch_ready for the lost request; a new ch0 request completes normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=8, mem_ready never asserted -> mem_init cycle 2; ch_ready[0]=ch_err[0]=1 in cycle 10 with ch_rdata 0; a mem_ready in cycle 12 is ignored.
